// File: rtl/nmea_pkg.sv
// Shared constants, state encoding and field bundle for the NMEA RMC
// sentence transmitter.
package nmea_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    localparam logic [5:0] RMC_LEN      = 6'd63;
    localparam logic [5:0] CKS_LAST_IDX = 6'd57;

    localparam logic [5:0] IDX_CKS_HI   = 6'd59;
    localparam logic [5:0] IDX_CKS_LO   = 6'd60;
    localparam logic [5:0] IDX_LF       = 6'd62;

    localparam logic [5:0] OFS_TIME     = 6'd7;
    localparam logic [5:0] OFS_STATUS   = 6'd17;
    localparam logic [5:0] OFS_LAT      = 6'd19;
    localparam logic [5:0] OFS_NS       = 6'd30;
    localparam logic [5:0] OFS_LON      = 6'd32;
    localparam logic [5:0] OFS_EW       = 6'd44;
    localparam logic [5:0] OFS_DATE     = 6'd48;
    localparam logic [5:0] OFS_MODE     = 6'd57;

    typedef enum logic [1:0] {IDLE, SEND, CKS, TERM} state_t;

    typedef struct packed {
        logic [71:0] utc;
        logic [7:0]  status;
        logic [79:0] lat;
        logic [7:0]  ns;
        logic [87:0] lon;
        logic [7:0]  ew;
        logic [47:0] date;
    } rmc_fields_t;

    // Byte k of a multi-byte ASCII field, left-aligned in an 88-bit word.
    function automatic logic [7:0] pick_byte(input logic [87:0] v, input logic [5:0] k);
        logic [87:0] sh;
        sh = v << {k, 3'b000};
        return sh[87:80];
    endfunction

endpackage

// File: rtl/nmea_rmc_tx_if.sv
// Byte-wide valid/ready stream from the sentence builder to the UART transmitter.
interface nmea_rmc_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/nmea_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module nmea_hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h30 + {4'h0, nibble};
        if (nibble > 4'd9) begin
            ascii = 8'h37 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/nmea_rmc_tx.sv
// Serialises a $GPRMC sentence from latched ASCII fields, appending the
// running XOR checksum as two hex digits and a CR LF terminator.
module nmea_rmc_tx
    import nmea_pkg::*;
#(
    parameter logic [7:0]  MODE_CHAR = 8'h41,
    parameter logic [15:0] TALKER_ID = 16'h4750
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [71:0]   time_in,
    input  logic [7:0]    status_in,
    input  logic [79:0]   lat_in,
    input  logic [7:0]    ns_in,
    input  logic [87:0]   lon_in,
    input  logic [7:0]    ew_in,
    input  logic [47:0]   date_in,
    nmea_rmc_tx_if.master tx,
    output logic          busy,
    output logic          done
);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  cks_q, cks_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    rmc_fields_t fields_q, fields_d;

    logic [7:0]  cks_hi_ascii;
    logic [7:0]  cks_lo_ascii;
    logic        xfer;
    logic [5:0]  idx_next;

    nmea_hex_ascii u_hex_hi (.nibble(cks_q[7:4]), .ascii(cks_hi_ascii));
    nmea_hex_ascii u_hex_lo (.nibble(cks_q[3:0]), .ascii(cks_lo_ascii));

    // Body byte at positions 0..57; anything not a field or header is a comma.
    function automatic logic [7:0] body_byte(input logic [5:0] i, input rmc_fields_t f);
        logic [7:0] b;
        b = ASCII_COMMA;
        if (i == 6'd0)                                    b = ASCII_DOLLAR;
        else if (i == 6'd1)                               b = TALKER_ID[15:8];
        else if (i == 6'd2)                               b = TALKER_ID[7:0];
        else if (i == 6'd3)                               b = 8'h52;
        else if (i == 6'd4)                               b = 8'h4D;
        else if (i == 6'd5)                               b = 8'h43;
        else if (i >= OFS_TIME && i < OFS_TIME + 6'd9)    b = pick_byte({f.utc, 16'h0}, i - OFS_TIME);
        else if (i == OFS_STATUS)                         b = f.status;
        else if (i >= OFS_LAT && i < OFS_LAT + 6'd10)     b = pick_byte({f.lat, 8'h0}, i - OFS_LAT);
        else if (i == OFS_NS)                             b = f.ns;
        else if (i >= OFS_LON && i < OFS_LON + 6'd11)     b = pick_byte(f.lon, i - OFS_LON);
        else if (i == OFS_EW)                             b = f.ew;
        else if (i >= OFS_DATE && i < OFS_DATE + 6'd6)    b = pick_byte({f.date, 40'h0}, i - OFS_DATE);
        else if (i == OFS_MODE)                           b = MODE_CHAR;
        return b;
    endfunction

    assign xfer     = valid_q & tx.tx_ready;
    assign idx_next = idx_q + 6'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cks_d    = cks_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fields_d = fields_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fields_d = '{utc: time_in, status: status_in, lat: lat_in, ns: ns_in,
                                 lon: lon_in, ew: ew_in, date: date_in};
                    cks_d    = 8'h00;
                    idx_d    = 6'd0;
                    data_d   = ASCII_DOLLAR;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    // Checksum follows accepted bytes only; '$' is excluded.
                    if (idx_q != 6'd0) begin
                        cks_d = cks_q ^ data_q;
                    end
                    idx_d = idx_next;
                    if (idx_q == CKS_LAST_IDX) begin
                        data_d  = ASCII_STAR;
                        state_d = CKS;
                    end else begin
                        data_d = body_byte(idx_next, fields_q);
                    end
                end
            end
            CKS: begin
                if (xfer) begin
                    idx_d = idx_next;
                    if (idx_q == IDX_CKS_HI - 6'd1) begin
                        data_d = cks_hi_ascii;
                    end else if (idx_q == IDX_CKS_LO - 6'd1) begin
                        data_d = cks_lo_ascii;
                    end else begin
                        data_d  = ASCII_CR;
                        state_d = TERM;
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    if (idx_q == IDX_LF) begin
                        idx_d   = 6'd0;
                        data_d  = 8'h00;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_next;
                        data_d = ASCII_LF;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 6'd0;
            cks_q    <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fields_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cks_q    <= cks_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fields_q <= fields_d;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
